// File: rtl/led_ctrl_pkg.sv
// Shared mode codes, FSM encoding and defaults for the LED sweep sequencer.
// Imported by led_sweep_ctrl and led_prescaler.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    MODE_SCAN  = 2'd0,
    MODE_BLINK = 2'd1,
    MODE_FILL  = 2'd2,
    MODE_OFF   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DWELL = 2'd2
  } state_e;

  localparam int unsigned DIV_W_DEFAULT    = 27;
  localparam int unsigned DIV_RESET_PERIOD = 12_500_000;
  localparam logic [1:0]  WIDTH_RESET      = 2'd2;

  // cfg_width encodes bar length minus one
  function automatic logic [2:0] bar_len(input logic [1:0] w);
    return {1'b0, w} + 3'd1;
  endfunction

endpackage

// File: rtl/led_prescaler.sv
// Step timebase: cnt runs 0..div and wraps, tick marks the div cycle.
// Held at zero while stopped and cleared whenever a new config lands.
module led_prescaler
  import led_ctrl_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             run,
  input  logic             clear,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_reg <= '0;
    end else if (clear || !run || (cnt_reg == div)) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

  assign tick = run && (cnt_reg == div);

endmodule

// File: rtl/led_sweep_ctrl.sv
// LED bank sequencer: scanning bar with end dwell, blink, and bar-fill modes.
// New config waits in a pending slot and is applied only at sweep boundaries.
module led_sweep_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned NLED        = 8,
  parameter int unsigned DIV_W       = 27,
  parameter int unsigned DIV_DEFAULT = DIV_RESET_PERIOD,
  parameter int unsigned DWELL       = 2
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [1:0]       cfg_width,
  output logic [NLED-1:0]  led_out,
  output logic             step_tick,
  output logic             busy
);

  localparam int unsigned POS_W = $clog2(NLED);
  localparam int unsigned N_W   = $clog2(NLED + 1);
  localparam int unsigned DW_W  = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DW_W-1:0] DWELL_LAST = (DWELL > 0) ? DW_W'(DWELL - 1) : '0;

  state_e           state_reg, state_next;
  mode_e            mode_reg, pend_mode_reg, mode_eff;
  logic [DIV_W-1:0] div_reg, pend_div_reg;
  logic [1:0]       width_reg, pend_width_reg, width_eff;
  logic             pend_reg;
  logic [POS_W-1:0] pos_reg, pos_next;
  logic             dir_reg, dir_next;        // 0 = up, 1 = down
  logic [DW_W-1:0]  dwell_reg, dwell_next;
  logic             phase_reg, phase_next;
  logic [N_W-1:0]   fill_reg, fill_next;
  logic [NLED-1:0]  led_reg, led_next, scan_pat, fill_pat;
  logic             step_tick_reg;
  logic             tick, apply, take, reach_end;
  logic [POS_W:0]   pos_max;

  led_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk     (clk),
    .aresetn (aresetn),
    .run     (state_reg != ST_IDLE),
    .clear   (apply),
    .div     (div_reg),
    .tick    (tick)
  );

  assign take    = cfg_valid && !pend_reg;
  assign pos_max = (POS_W+1)'(NLED) - (POS_W+1)'(bar_len(width_reg));

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    pos_next   = pos_reg;
    dir_next   = dir_reg;
    dwell_next = dwell_reg;
    phase_next = phase_reg;
    fill_next  = fill_reg;
    apply      = 1'b0;
    reach_end  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        apply = pend_reg;
        if (enable) begin
          state_next = ST_RUN;
          pos_next   = '0;
          dir_next   = 1'b0;
          phase_next = 1'b0;
          fill_next  = '0;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          state_next = ST_IDLE;
          apply      = pend_reg;
        end else if (tick) begin
          case (mode_reg)
            MODE_SCAN: begin
              if (!dir_reg) begin
                if ({1'b0, pos_reg} < pos_max) pos_next = pos_reg + POS_W'(1);
                reach_end = ({1'b0, pos_reg} + (POS_W+1)'(1) >= pos_max);
              end else begin
                if (pos_reg != '0) pos_next = pos_reg - POS_W'(1);
                reach_end = (pos_reg <= POS_W'(1));
              end
              // the bottom of a downward sweep is the only clean SCAN boundary
              if (reach_end && dir_reg && pend_reg) begin
                apply = 1'b1;
              end else if (reach_end) begin
                if (DWELL == 0) begin
                  dir_next = ~dir_reg;
                end else begin
                  state_next = ST_DWELL;
                  dwell_next = '0;
                end
              end
            end
            MODE_BLINK: begin
              apply      = pend_reg;
              phase_next = ~phase_reg;
            end
            MODE_FILL: begin
              apply     = pend_reg;
              fill_next = (fill_reg == N_W'(NLED)) ? '0 : fill_reg + N_W'(1);
            end
            default: apply = pend_reg;
          endcase
        end
      end
      ST_DWELL: begin
        if (!enable) begin
          state_next = ST_IDLE;
          apply      = pend_reg;
        end else if (tick) begin
          if (dwell_reg == DWELL_LAST) begin
            state_next = ST_RUN;
            dir_next   = ~dir_reg;
          end else begin
            dwell_next = dwell_reg + DW_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
    if (apply) begin
      pos_next   = '0;
      dir_next   = 1'b0;
      dwell_next = '0;
      phase_next = 1'b0;
      fill_next  = '0;
    end
  end

  assign width_eff = apply ? pend_width_reg : width_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NLED; gi++) begin : g_pat
      localparam logic [POS_W:0] IDX = (POS_W+1)'(gi);
      assign scan_pat[gi] = (IDX >= {1'b0, pos_next}) &&
                            (IDX < {1'b0, pos_next} + (POS_W+1)'(bar_len(width_eff)));
      assign fill_pat[gi] = (N_W'(gi) < fill_next);
    end
  endgenerate

  // LED drive is registered from next-state values so a tick shows one cycle later
  always_comb begin
    mode_eff = apply ? pend_mode_reg : mode_reg;
    led_next = '0;
    if (state_next != ST_IDLE) begin
      case (mode_eff)
        MODE_SCAN:  led_next = scan_pat;
        MODE_BLINK: led_next = phase_next ? '0 : '1;
        MODE_FILL:  led_next = fill_pat;
        default:    led_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      pos_reg        <= '0;
      dir_reg        <= 1'b0;
      dwell_reg      <= '0;
      phase_reg      <= 1'b0;
      fill_reg       <= '0;
      mode_reg       <= MODE_SCAN;
      div_reg        <= DIV_W'(DIV_DEFAULT);
      width_reg      <= WIDTH_RESET;
      pend_reg       <= 1'b0;
      pend_mode_reg  <= MODE_SCAN;
      pend_div_reg   <= '0;
      pend_width_reg <= '0;
      led_reg        <= '0;
      step_tick_reg  <= 1'b0;
    end else begin
      pos_reg       <= pos_next;
      dir_reg       <= dir_next;
      dwell_reg     <= dwell_next;
      phase_reg     <= phase_next;
      fill_reg      <= fill_next;
      led_reg       <= led_next;
      step_tick_reg <= tick;
      if (apply) begin
        mode_reg  <= pend_mode_reg;
        div_reg   <= pend_div_reg;
        width_reg <= pend_width_reg;
      end
      if (take) begin
        pend_reg       <= 1'b1;
        pend_mode_reg  <= mode_e'(cfg_mode);
        pend_div_reg   <= cfg_div;
        pend_width_reg <= cfg_width;
      end else if (apply) begin
        pend_reg <= 1'b0;
      end
    end
  end

  assign cfg_ready = ~pend_reg;
  assign led_out   = led_reg;
  assign step_tick = step_tick_reg;
  assign busy      = (state_reg != ST_IDLE);

endmodule
